// File: rtl/fsk_pkg.sv
// Shared constants and types for the zero-crossing FSK demodulator.
// The interval and symbol-counter widths follow from the constants below.
package fsk_pkg;

    localparam int SAMPLES_PER_SYM = 64;
    localparam int HALF_THRESH     = 24;
    localparam int DEB             = 2;
    localparam int MAX_HALF        = 48;

    localparam int LEN_W = $clog2(MAX_HALF + 1);
    localparam int SYM_W = $clog2(SAMPLES_PER_SYM);

    typedef logic signed [7:0] sample_t;
    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [SYM_W-1:0]  sym_t;

    // A short half-period means the '1' tone.
    function automatic logic isShort(input len_t halfLen);
        return halfLen <= len_t'(HALF_THRESH);
    endfunction

endpackage

// File: rtl/fsk_demod_if.sv
// Sample stream in, recovered bit stream out.
interface fsk_demod_if;
    import fsk_pkg::*;

    sample_t sample_in;
    logic    sample_en;
    logic    bit_out;
    logic    bit_valid;
    logic    carrier_ok;

    modport master (output sample_in, sample_en, input bit_out, bit_valid, carrier_ok);
    modport slave  (input sample_in, sample_en, output bit_out, bit_valid, carrier_ok);
endinterface

// File: rtl/fsk_zc_detector.sv
// Debounced sign tracking and half-period measurement between accepted crossings.
// xing/len/timeout are combinational and refer to the sample presented this cycle.
module fsk_zc_detector
    import fsk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sampleEn,
    input  logic sampleSign,
    output logic xing,
    output len_t len,
    output logic timeout
);

    localparam int DEB_W = $clog2(DEB + 1);

    logic             accSign;
    logic [DEB_W-1:0] devCnt;
    len_t             cnt;
    logic             differs;

    assign differs = sampleSign != accSign;
    assign xing    = sampleEn && differs && (devCnt == DEB_W'(DEB - 1));
    // The crossing sample itself belongs to the interval it closes.
    assign len     = cnt + len_t'(1);
    assign timeout = sampleEn && !xing && (cnt == len_t'(MAX_HALF - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accSign <= 1'b0;
            devCnt  <= '0;
            cnt     <= '0;
        end else if (sampleEn) begin
            if (xing) begin
                accSign <= sampleSign;
                devCnt  <= '0;
                cnt     <= '0;
            end else begin
                devCnt <= differs ? devCnt + DEB_W'(1) : '0;
                if (cnt != len_t'(MAX_HALF)) begin
                    cnt <= cnt + len_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fsk_demod.sv
// Non-coherent FSK demodulator: arms on the first crossing, locks on two valid ones,
// resyncs the symbol counter on decision changes and strobes bits at mid-symbol.
module fsk_demod
    import fsk_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    fsk_demod_if.slave bus
);

    localparam sym_t MID_SYM  = sym_t'(SAMPLES_PER_SYM / 2 - 1);
    localparam sym_t LAST_SYM = sym_t'(SAMPLES_PER_SYM - 1);

    logic xing;
    logic timeout;
    len_t len;

    logic armed;
    logic seenValid;
    logic dec;
    logic carrierOk;
    logic bitOut;
    logic bitValid;
    sym_t symCnt;

    logic validXing;
    logic decNew;
    logic resync;
    logic midStrobe;
    logic unusedMagnitude;

    assign unusedMagnitude = ^bus.sample_in[6:0];

    fsk_zc_detector uZc (
        .clk        (clk),
        .rst_n      (rst_n),
        .sampleEn   (bus.sample_en),
        .sampleSign (bus.sample_in[7]),
        .xing       (xing),
        .len        (len),
        .timeout    (timeout)
    );

    always_comb begin
        validXing = xing && armed;
        decNew    = isShort(len);
        resync    = validXing && (decNew != dec);
        // A resync cycle restarts the symbol, so its midpoint is not yet due.
        midStrobe = bus.sample_en && (symCnt == MID_SYM) && carrierOk && !resync && !timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            seenValid <= 1'b0;
            dec       <= 1'b0;
            carrierOk <= 1'b0;
            bitOut    <= 1'b0;
            bitValid  <= 1'b0;
            symCnt    <= '0;
        end else begin
            bitValid <= 1'b0;
            if (bus.sample_en) begin
                if (timeout) begin
                    armed     <= 1'b0;
                    seenValid <= 1'b0;
                    carrierOk <= 1'b0;
                end else if (xing) begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else begin
                        dec       <= decNew;
                        seenValid <= 1'b1;
                        if (seenValid) begin
                            carrierOk <= 1'b1;
                        end
                    end
                end

                symCnt <= (resync || symCnt == LAST_SYM) ? '0 : symCnt + sym_t'(1);

                if (midStrobe) begin
                    bitOut   <= dec;
                    bitValid <= 1'b1;
                end
            end
        end
    end

    assign bus.bit_out    = bitOut;
    assign bus.bit_valid  = bitValid;
    assign bus.carrier_ok = carrierOk;

endmodule

// File: tb/tb_fsk_demod.sv
// Directed bench for fsk_demod: sample-indexed reference model compared every clock,
// plus hand-derived expectations for lock time, strobe counts and recovered bits.
module tb_fsk_demod;
    import fsk_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fsk_demod_if bus();

    fsk_demod dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: everything is expressed in absolute sample indices.
    int  n        = 0;   // index of the next sample
    int  lastX    = -1;  // index of the last accepted crossing (or of the sample before reset)
    int  base     = 0;   // index at which the current symbol started
    bit  signHist [0:8191];
    bit  mSign, mArmed, mSeen, mDec, mOk;
    bit  eBitOut, eValid;
    bit  s, xingM, tmoM, midM, resyncM, oldDec, decM;
    int  lenM, lM;

    int  pulseCnt = 0;
    int  capWord  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastX   = n - 1;
            base    = n;
            mSign   = 1'b0;
            mArmed  = 1'b0;
            mSeen   = 1'b0;
            mDec    = 1'b0;
            mOk     = 1'b0;
            eBitOut = 1'b0;
            eValid  = 1'b0;
        end else begin
            eValid = 1'b0;
            if (bus.sample_en) begin
                s           = bus.sample_in[7];
                signHist[n] = s;
                lenM        = n - lastX;
                xingM       = 1'b0;
                if (lenM >= DEB) begin
                    xingM = 1'b1;
                    for (int k = 0; k < DEB; k++) begin
                        if (signHist[n - k] == mSign) xingM = 1'b0;
                    end
                end
                tmoM    = !xingM && (lenM == MAX_HALF);
                midM    = (((n - base) % SAMPLES_PER_SYM) == SAMPLES_PER_SYM / 2 - 1) && mOk && !tmoM;
                resyncM = 1'b0;
                oldDec  = mDec;
                if (tmoM) begin
                    mArmed = 1'b0;
                    mOk    = 1'b0;
                    mSeen  = 1'b0;
                end else if (xingM) begin
                    lM    = (lenM > MAX_HALF) ? MAX_HALF + 1 : lenM;
                    mSign = s;
                    lastX = n;
                    if (!mArmed) begin
                        mArmed = 1'b1;
                    end else begin
                        decM    = (lM <= HALF_THRESH);
                        resyncM = (decM != mDec);
                        mDec    = decM;
                        if (mSeen) mOk = 1'b1;
                        mSeen = 1'b1;
                    end
                end
                if (resyncM) base = n + 1;
                if (midM && !resyncM) begin
                    eBitOut = oldDec;
                    eValid  = 1'b1;
                end
                n++;
            end
        end
        #1;
        chk("cyc_bit_out", bus.bit_out, eBitOut);
        chk("cyc_bit_valid", bus.bit_valid, eValid);
        chk("cyc_carrier_ok", bus.carrier_ok, mOk);
        if (bus.bit_valid) begin
            pulseCnt++;
            capWord = (capWord << 1) | int'(bus.bit_out);
        end
    end

    int phase = 0;

    function automatic int sineSample(input int p);
        real r;
        r = 127.0 * $sin(2.0 * 3.14159265358979 * p / 64.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    task automatic sendSample(input int v);
        @(negedge clk);
        bus.sample_in = 8'(v);
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Continuous-phase tone: '0' advances one 1/64 cycle per sample, '1' two.
    task automatic sendBits(input bit b, input int count);
        for (int i = 0; i < count; i++) begin
            sendSample(sineSample(phase));
            phase = (phase + (b ? 2 : 1)) % 64;
        end
    endtask

    task automatic sendConst(input int v, input int count);
        for (int i = 0; i < count; i++) sendSample(v);
    endtask

    task automatic clearCapture();
        pulseCnt = 0;
        capWord  = 0;
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_rst_bit_out"}, bus.bit_out, 0);
        chk({tag, "_rst_bit_valid"}, bus.bit_valid, 0);
        chk({tag, "_rst_carrier_ok"}, bus.carrier_ok, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        phase = 0;
        clearCapture();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_in = '0;
        bus.sample_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("init_bit_out", bus.bit_out, 0);
        chk("init_carrier_ok", bus.carrier_ok, 0);

        // Carrier '0': lock after the crossing at sample 98, strobes at 159+64k.
        sendBits(1'b0, 512);
        $display("T1 carrier0 carrier_ok=%0d bit_out=%0d pulses=%0d", bus.carrier_ok, bus.bit_out, pulseCnt);
        chk("t1_carrier_ok", bus.carrier_ok, 1);
        chk("t1_bit_out", bus.bit_out, 0);
        chk("t1_pulses", pulseCnt, 6);

        // Carrier '1': resync at sample 33, lock at 50, strobes at 65+64k.
        doReset("t2");
        sendBits(1'b1, 512);
        $display("T2 carrier1 carrier_ok=%0d bit_out=%0d pulses=%0d", bus.carrier_ok, bus.bit_out, pulseCnt);
        chk("t2_carrier_ok", bus.carrier_ok, 1);
        chk("t2_bit_out", bus.bit_out, 1);
        chk("t2_pulses", pulseCnt, 7);

        // Preamble 0,0,0 then 1,0,1,1,0 then 0: strobes recover 0,1,0,1,1,0.
        doReset("t3");
        sendBits(1'b0, 192);
        sendBits(1'b1, 64);
        sendBits(1'b0, 64);
        sendBits(1'b1, 64);
        sendBits(1'b1, 64);
        sendBits(1'b0, 64);
        sendBits(1'b0, 64);
        $display("T3 pattern pulses=%0d bits=%06b", pulseCnt, capWord[5:0]);
        chk("t3_pulses", pulseCnt, 6);
        chk("t3_bits", capWord, 22);

        // Carrier loss: last crossing at 257, timeout on sample 305, relock at 414.
        doReset("t4");
        sendBits(1'b0, 256);
        sendConst(50, 40);
        chk("t4_hold", bus.carrier_ok, 1);
        sendConst(50, 20);
        $display("T4 const carrier_ok=%0d", bus.carrier_ok);
        chk("t4_lost", bus.carrier_ok, 0);
        clearCapture();
        phase = 0;
        sendBits(1'b0, 34);
        chk("t4_quiet_pulses", pulseCnt, 0);
        chk("t4_armed_only", bus.carrier_ok, 0);
        sendBits(1'b0, 100);
        $display("T4 relock carrier_ok=%0d", bus.carrier_ok);
        chk("t4_relock", bus.carrier_ok, 1);

        // One-sample negative glitch in a positive half: no crossing, strobes at 223/287/351.
        doReset("t5");
        sendBits(1'b0, 200);
        clearCapture();
        sendSample(-5);
        phase = (phase + 1) % 64;
        sendBits(1'b0, 199);
        $display("T5 glitch carrier_ok=%0d bit_out=%0d pulses=%0d", bus.carrier_ok, bus.bit_out, pulseCnt);
        chk("t5_carrier_ok", bus.carrier_ok, 1);
        chk("t5_bit_out", bus.bit_out, 0);
        chk("t5_pulses", pulseCnt, 3);

        // Mid-stream reset on a locked '1' carrier: arm at 210, relock at 242.
        doReset("t6pre");
        sendBits(1'b1, 200);
        chk("t6_before_bit_out", bus.bit_out, 1);
        chk("t6_before_carrier_ok", bus.carrier_ok, 1);
        begin
            int keepPhase;
            keepPhase = phase;
            doReset("t6");
            phase = keepPhase;
        end
        sendBits(1'b1, 20);
        chk("t6_armed_only", bus.carrier_ok, 0);
        sendBits(1'b1, 40);
        $display("T6 reset relock carrier_ok=%0d", bus.carrier_ok);
        chk("t6_relock", bus.carrier_ok, 1);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
